dot_product_reader: RTL and testbench

- Read-side sequencer for the dotProduct datapath.
- Drives the shared read port (read enable, read address) of two single-port-write RAMs holding vectors A and B. Both RAMs have a registered read with 1-cycle latency.
- Multiply-accumulates the returned element pairs (unsigned) and presents the dot product on a valid/ready result interface.
- Sits between the two vector memories and the downstream consumer. It is the reader counterpart of the memory write path.

---
 rtl/dot_product_reader.sv | 171 +++++++++++++++++
 tb/tb_dot_product_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_reader.sv
// dot_product_reader: read-side sequencer for the dotProduct datapath.
// It walks the shared read port of the A and B vector memories and
// multiply-accumulates the returned element pairs. Both memories have a
// registered read, so data arrives one cycle after the address. The finished
// sum is offered on a valid/ready result interface.
module dot_product_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                    r_state;
  state_t                    w_next_state;

  // Element count latched at start, and the number of reads issued so far.
  // r_count is one bit wider than the address, so a full-length vector
  // (all-ones last address) ends on the count compare and never wraps into
  // an extra read.
  logic [ADDR_WIDTH:0]       r_len;
  logic [ADDR_WIDTH:0]       r_count;

  logic                      r_read_en;
  logic [ADDR_WIDTH-1:0]     r_read_address;

  // One-cycle-delayed read_en. It marks the cycles in which a_data/b_data
  // carry a pair that was actually requested.
  logic                      r_data_valid;

  logic [ACC_WIDTH-1:0]      r_acc;
  logic [ACC_WIDTH-1:0]      r_result;
  logic                      r_result_valid;

  logic                      w_len_zero;
  logic                      w_last_issued;
  logic [2*DATA_WIDTH-1:0]   w_product;
  logic [ACC_WIDTH-1:0]      w_acc_next;

  assign w_len_zero    = (len == '0);
  assign w_last_issued = (r_count == r_len);

  // The product is computed at full width and zero-extended. ACC_WIDTH
  // leaves room for 2^ADDR_WIDTH maximal products, so the sum cannot overflow.
  assign w_product  = a_data * b_data;
  assign w_acc_next = r_data_valid ? (r_acc + ACC_WIDTH'(w_product)) : r_acc;

  // State register; reset returns to IDLE regardless of other inputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. start is only looked at in IDLE.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_len_zero ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_last_issued) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (result_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Read sequencing, accumulation and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len          <= '0;
      r_count        <= '0;
      r_read_en      <= 1'b0;
      r_read_address <= '0;
      r_data_valid   <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_data_valid <= r_read_en;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_acc   <= '0;
            r_count <= COUNT_ONE;
            if (w_len_zero) begin
              // Empty vector: the dot product is zero and is ready at once.
              r_result       <= '0;
              r_result_valid <= 1'b1;
            end else begin
              r_read_en      <= 1'b1;
              r_read_address <= '0;
            end
          end
        end
        S_READ: begin
          r_acc <= w_acc_next;
          if (w_last_issued) begin
            // Address holds at len-1; the last pair is still in flight.
            r_read_en <= 1'b0;
          end else begin
            // The count of reads issued equals the next address to read.
            r_read_address <= r_count[ADDR_WIDTH-1:0];
            r_count        <= r_count + COUNT_ONE;
          end
        end
        S_DRAIN: begin
          // Final pair arrives this cycle; fold it straight into the result.
          r_acc          <= w_acc_next;
          r_result       <= w_acc_next;
          r_result_valid <= 1'b1;
        end
        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
          end
        end
        default: begin
          r_read_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign read_en      = r_read_en;
  assign read_address = r_read_address;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_dot_product_reader.sv
// Directed bench for dot_product_reader. Two small behavioural memories with
// a registered 1-cycle read feed a_data/b_data. Outputs are sampled 1 ns
// after each rising edge; inputs are driven at the same point.
module tb_dot_product_reader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 2 * DW + AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  logic          read_en;
  logic [AW-1:0] read_address;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          result_ready;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  int checks;
  int errors;

  dot_product_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .read_en      (read_en),
    .read_address (read_address),
    .a_data       (a_data),
    .b_data       (b_data),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (read_en) begin
      a_data <= mem_a[read_address];
      b_data <= mem_b[read_address];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_1234_5678();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    len          = '0;
    result_ready = 1'b0;
    a_data       = '0;
    b_data       = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    // ---- reset state ----
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy",    32'(busy),         0);
    check("rst_read_en", 32'(read_en),      0);
    check("rst_addr",    32'(read_address), 0);
    check("rst_result",  32'(result),       0);
    check("rst_valid",   32'(result_valid), 0);

    // ---- test 1: [1,2,3,4].[5,6,7,8] = 70, ready held high ----
    load_1234_5678();
    result_ready = 1'b1;
    start = 1'b1;
    len   = 5'd4;
    tick();                                   // E0
    start = 1'b0;
    check("t1_busy_e0", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin         // after E0..E3
      check("t1_read_en", 32'(read_en),      1);
      check("t1_addr",    32'(read_address), 32'(k));
      check("t1_valid_early", 32'(result_valid), 0);
      if (k < 3) tick();
    end
    tick();                                   // E4
    check("t1_read_en_off", 32'(read_en),      0);
    check("t1_addr_hold",   32'(read_address), 3);
    check("t1_valid_e4",    32'(result_valid), 0);
    tick();                                   // E5
    check("t1_valid_e5", 32'(result_valid), 1);
    check("t1_result",   32'(result),       70);
    tick();                                   // E6 handshake
    check("t1_valid_drop", 32'(result_valid), 0);
    check("t1_busy_drop",  32'(busy),         0);
    check("t1_result_keep", 32'(result),      70);

    // ---- test 2: 16 x 0xFF . 0xFF = 1040400 ----
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
    start = 1'b1;
    len   = 5'd16;
    tick();                                   // E0
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("t2_read_en", 32'(read_en),      1);
      check("t2_addr",    32'(read_address), 32'(k));
      tick();
    end
    check("t2_read_en_off", 32'(read_en),      0);  // E16
    check("t2_addr_hold",   32'(read_address), 15);
    check("t2_valid_e16",   32'(result_valid), 0);
    tick();                                   // E17
    check("t2_valid",  32'(result_valid), 1);
    check("t2_result", 32'(result),       32'd1040400);
    tick();
    check("t2_valid_drop", 32'(result_valid), 0);

    // ---- test 3: len = 0 ----
    start = 1'b1;
    len   = 5'd0;
    tick();                                   // E0
    start = 1'b0;
    check("t3_read_en", 32'(read_en),      0);
    check("t3_valid",   32'(result_valid), 1);
    check("t3_result",  32'(result),       0);
    check("t3_busy",    32'(busy),         1);
    tick();
    check("t3_valid_drop", 32'(result_valid), 0);
    check("t3_busy_drop",  32'(busy),         0);

    // ---- test 4: backpressure, ignored starts, then [2,2].[2,2] = 8 ----
    load_1234_5678();
    result_ready = 1'b0;
    start = 1'b1;
    len   = 5'd4;
    tick();                                   // E0
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();       // E1..E5
    check("t4_valid",  32'(result_valid), 1);
    check("t4_result", 32'(result),       70);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      len   = 5'd1;
      tick();
      check("t4_hold_valid",   32'(result_valid), 1);
      check("t4_hold_result",  32'(result),       70);
      check("t4_hold_busy",    32'(busy),         1);
      check("t4_hold_read_en", 32'(read_en),      0);
    end
    // start is still high through the handshake edge and must be ignored.
    result_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t4_valid_drop", 32'(result_valid), 0);
    check("t4_busy_drop",  32'(busy),         0);
    tick();
    check("t4_no_restart", 32'(read_en), 0);
    mem_a[0] = 8'd2; mem_a[1] = 8'd2;
    mem_b[0] = 8'd2; mem_b[1] = 8'd2;
    start = 1'b1;
    len   = 5'd2;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    check("t4b_valid_e2", 32'(result_valid), 0);
    tick();                                   // E3
    check("t4b_valid",  32'(result_valid), 1);
    check("t4b_result", 32'(result),       8);
    tick();

    // ---- test 5: reset two cycles into an 8-element read ----
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'd9;
      mem_b[i] = 8'd9;
    end
    start = 1'b1;
    len   = 5'd8;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    check("t5_mid_read", 32'(read_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy",    32'(busy),         0);
    check("t5_read_en", 32'(read_en),      0);
    check("t5_addr",    32'(read_address), 0);
    check("t5_result",  32'(result),       0);
    check("t5_valid",   32'(result_valid), 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_no_valid", 32'(result_valid), 0);
      check("t5_no_read",  32'(read_en),      0);
    end
    load_1234_5678();
    start = 1'b1;
    len   = 5'd4;
    tick();                                   // E0
    start = 1'b0;
    check("t5b_addr0", 32'(read_address), 0);
    for (int k = 0; k < 4; k++) tick();       // E1..E4
    check("t5b_read_en_off", 32'(read_en),      0);
    check("t5b_valid_e4",    32'(result_valid), 0);
    tick();                                   // E5
    check("t5b_valid",  32'(result_valid), 1);
    check("t5b_result", 32'(result),       70);
    tick();
    check("t5b_valid_drop", 32'(result_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
